// File: rtl/sega_joy_scanner_pkg.sv
// joy_pkg: shared constants for the Sega DB9 joystick poll sequencer.
//   - STEP_*  : protocol step indices within the 256-step scan
//   - PIN_*   : bit positions in the 6-bit pin vector {p9, p6, R, L, D, U}
//   - BTN_*   : bit positions in the 12-bit button word {M,X,Y,Z,S,A,C,B,R,L,D,U}
//   - JOY_IDLE: released-state button word (active-low)
package joy_pkg;

    localparam int unsigned PIN_W = 6;
    localparam int unsigned JOY_W = 12;

    localparam logic [7:0] STEP_SEL0   = 8'd0;
    localparam logic [7:0] STEP_SEL1   = 8'd1;
    localparam logic [7:0] STEP_RD_HI  = 8'd2;
    localparam logic [7:0] STEP_RD_LO  = 8'd3;
    localparam logic [7:0] STEP_SEL4   = 8'd4;
    localparam logic [7:0] STEP_RD_ID  = 8'd5;
    localparam logic [7:0] STEP_RD_EXT = 8'd6;
    localparam logic [7:0] STEP_COMMIT = 8'd7;

    localparam int unsigned PIN_U  = 0;
    localparam int unsigned PIN_D  = 1;
    localparam int unsigned PIN_L  = 2;
    localparam int unsigned PIN_R  = 3;
    localparam int unsigned PIN_P6 = 4;
    localparam int unsigned PIN_P9 = 5;

    localparam int unsigned BTN_U = 0;
    localparam int unsigned BTN_D = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_B = 4;
    localparam int unsigned BTN_C = 5;
    localparam int unsigned BTN_A = 6;
    localparam int unsigned BTN_S = 7;
    localparam int unsigned BTN_Z = 8;
    localparam int unsigned BTN_Y = 9;
    localparam int unsigned BTN_X = 10;
    localparam int unsigned BTN_M = 11;

    localparam logic [JOY_W-1:0] JOY_IDLE = 12'hFFF;

    // True when all four direction pins read low: the 6-button pad's ID phase.
    function automatic logic dirs_all_low(input logic [3:0] dirs);
        return dirs == 4'b0000;
    endfunction

endpackage

// File: rtl/sega_joy_scanner_if.sv
// sega_joy_scanner_if: pin/button bundle between the DB9 ports, the scanner
// and the core's input mapping.
//   joy1_i, joy2_i : raw active-low port pins {p9, p6, R, L, D, U}
//   joyX_p7_o      : shared select line
//   joy1_o, joy2_o : committed active-low button words {M,X,Y,Z,S,A,C,B,R,L,D,U}
//   six_btn_o      : per-port 6-button pad flag
//   scan_done_o    : one-cycle pulse on commit
// modport master: the scanner; modport slave: the board/core side.
interface sega_joy_scanner_if;
    import joy_pkg::*;

    logic [PIN_W-1:0] joy1_i;
    logic [PIN_W-1:0] joy2_i;
    logic             joyX_p7_o;
    logic [JOY_W-1:0] joy1_o;
    logic [JOY_W-1:0] joy2_o;
    logic [1:0]       six_btn_o;
    logic             scan_done_o;

    modport master (
        input  joy1_i, joy2_i,
        output joyX_p7_o, joy1_o, joy2_o, six_btn_o, scan_done_o
    );

    modport slave (
        output joy1_i, joy2_i,
        input  joyX_p7_o, joy1_o, joy2_o, six_btn_o, scan_done_o
    );

endinterface

// File: rtl/sega_joy_scanner_capture.sv
// sega_pad_capture: per-port capture path.
// Synchronises the pins, builds the button word in a shadow register over
// steps 2..6 and copies it to the output register in one cycle at step 7.
//   clk_sys, reset : clock, async active-high reset
//   tick, step     : step boundary strobe and current step index from the top
//   pins_i         : raw active-low pins {p9, p6, R, L, D, U}
//   buttons_o      : committed active-low button word
//   six_o          : committed 6-button flag
module sega_pad_capture
    import joy_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             tick,
    input  logic [7:0]       step,
    input  logic [PIN_W-1:0] pins_i,
    output logic [JOY_W-1:0] buttons_o,
    output logic             six_o
);

    logic [PIN_W-1:0] sync_meta;
    logic [PIN_W-1:0] sync_q;
    logic [JOY_W-1:0] shadow;
    logic [JOY_W-1:0] word_q;
    logic             six_pend;
    logic             six_q;
    logic [3:0]       dirs;

    assign dirs = {sync_q[PIN_R], sync_q[PIN_L], sync_q[PIN_D], sync_q[PIN_U]};

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync_meta <= '1;
            sync_q    <= '1;
            shadow    <= JOY_IDLE;
            six_pend  <= 1'b0;
            word_q    <= JOY_IDLE;
            six_q     <= 1'b0;
        end else begin
            sync_meta <= pins_i;
            sync_q    <= sync_meta;
            if (tick) begin
                case (step)
                    STEP_RD_HI: begin
                        {shadow[BTN_R], shadow[BTN_L], shadow[BTN_D], shadow[BTN_U]} <= dirs;
                        {shadow[BTN_C], shadow[BTN_B]} <= {sync_q[PIN_P9], sync_q[PIN_P6]};
                        six_pend <= 1'b0;
                    end
                    STEP_RD_LO: begin
                        // R and L both low with select low identifies a Mega Drive
                        // pad; anything else is a Master System pad with no S/A.
                        if (!sync_q[PIN_R] && !sync_q[PIN_L]) begin
                            {shadow[BTN_S], shadow[BTN_A]} <= {sync_q[PIN_P9], sync_q[PIN_P6]};
                        end else begin
                            {shadow[BTN_S], shadow[BTN_A], shadow[BTN_C], shadow[BTN_B]}
                                <= {2'b11, sync_q[PIN_P9], sync_q[PIN_P6]};
                        end
                    end
                    STEP_RD_ID: begin
                        six_pend <= dirs_all_low(dirs);
                    end
                    STEP_RD_EXT: begin
                        {shadow[BTN_M], shadow[BTN_X], shadow[BTN_Y], shadow[BTN_Z]}
                            <= six_pend ? dirs : 4'hF;
                    end
                    STEP_COMMIT: begin
                        word_q <= shadow;
                        six_q  <= six_pend;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign buttons_o = word_q;
    assign six_o     = six_q;

endmodule

// File: rtl/sega_joy_scanner.sv
// sega_joy_scanner: free-running Sega 3/6-button poll sequencer for two DB9 ports.
// Owns the step divider, the 8-bit step counter and the shared select line;
// each port's capture path lives in a sega_pad_capture instance.
//   STEP_DIV : clk_sys cycles per protocol step (>= 2)
//   clk_sys  : system clock
//   reset    : asynchronous active-high reset
//   joy      : pin/button bundle (master side)
module sega_joy_scanner
    import joy_pkg::*;
#(
    parameter int unsigned STEP_DIV = 1536
) (
    input  logic               clk_sys,
    input  logic               reset,
    sega_joy_scanner_if.master joy
);

    localparam int unsigned      DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       step_q, step_d;
    logic             p7_q, p7_d;
    logic             done_q, done_d;
    logic             tick;
    logic             six1, six2;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        step_d = step_q;
        p7_d   = p7_q;
        done_d = 1'b0;
        if (tick) begin
            step_d = step_q + 8'd1;
            done_d = (step_q == STEP_COMMIT);
            case (step_q)
                STEP_SEL0, STEP_RD_HI, STEP_SEL4, STEP_RD_EXT: p7_d = 1'b0;
                STEP_SEL1, STEP_RD_LO, STEP_RD_ID, STEP_COMMIT: p7_d = 1'b1;
                default: p7_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            step_q <= '0;
            p7_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            p7_q   <= p7_d;
            done_q <= done_d;
        end
    end

    sega_pad_capture u_cap1 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .tick      (tick),
        .step      (step_q),
        .pins_i    (joy.joy1_i),
        .buttons_o (joy.joy1_o),
        .six_o     (six1)
    );

    sega_pad_capture u_cap2 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .tick      (tick),
        .step      (step_q),
        .pins_i    (joy.joy2_i),
        .buttons_o (joy.joy2_o),
        .six_o     (six2)
    );

    assign joy.joyX_p7_o   = p7_q;
    assign joy.six_btn_o   = {six2, six1};
    assign joy.scan_done_o = done_q;

endmodule

// File: tb/tb_sega_joy_scanner.sv
// tb_sega_joy_scanner: self-checking bench for sega_joy_scanner (STEP_DIV=4).
// Behavioural pads (none / Master System / MD 3-button / MD 6-button) drive
// the pins from the select line; expected words come from constant vector
// tables and from a pad-type-level reference model.
module tb_sega_joy_scanner;

    localparam int unsigned STEP_DIV = 4;
    localparam logic [1:0] PAD_NONE = 2'd0;
    localparam logic [1:0] PAD_MS   = 2'd1;
    localparam logic [1:0] PAD_MD3  = 2'd2;
    localparam logic [1:0] PAD_MD6  = 2'd3;

    logic clk_sys = 1'b0;
    logic reset   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    sega_joy_scanner_if bus();

    sega_joy_scanner #(.STEP_DIV(STEP_DIV)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .joy     (bus)
    );

    // ---------------- pad model ----------------
    logic [1:0]  t1 = PAD_NONE, t2 = PAD_NONE;
    logic [11:0] b1 = 12'hFFF,  b2 = 12'hFFF;
    int          n_low  = 0;
    int          hi_cnt = 0;
    logic        p7_prev = 1'b1;

    // Pin image a pad presents for the current select level and the number of
    // select falling edges seen since its internal counter last timed out.
    function automatic logic [5:0] pad_pins(input logic [1:0] t, input logic [11:0] b,
                                            input logic p7, input int n);
        case (t)
            PAD_MS:  return b[5:0];
            PAD_MD3: return p7 ? b[5:0] : {b[7:6], 2'b00, b[1:0]};
            PAD_MD6: begin
                if (p7) return (n == 3) ? {b[5:4], b[11:8]} : b[5:0];
                if (n == 3) return {b[7:6], 4'b0000};
                if (n == 4) return {b[7:6], 4'b1111};
                return {b[7:6], 2'b00, b[1:0]};
            end
            default: return 6'h3F;
        endcase
    endfunction

    assign bus.joy1_i = pad_pins(t1, b1, bus.joyX_p7_o, n_low);
    assign bus.joy2_i = pad_pins(t2, b2, bus.joyX_p7_o, n_low);

    always @(posedge clk_sys) begin
        if (bus.joyX_p7_o === 1'b1) begin
            if (hi_cnt < 100000) hi_cnt = hi_cnt + 1;
        end else begin
            hi_cnt = 0;
        end
        if (hi_cnt > 200) n_low = 0;
        if (p7_prev === 1'b1 && bus.joyX_p7_o === 1'b0 && n_low < 7) n_low = n_low + 1;
        p7_prev = bus.joyX_p7_o;
    end

    // ---------------- reference model ----------------
    function automatic logic [12:0] ref_word(input logic [1:0] t, input logic [11:0] b);
        case (t)
            PAD_MS:  return {1'b0, 4'hF, 2'b11, b[5:0]};
            PAD_MD3: return {1'b0, 4'hF, b[7:0]};
            PAD_MD6: return {1'b1, b};
            default: return {1'b0, 12'hFFF};
        endcase
    endfunction

    function automatic logic exp_p7(input int s);
        return !(s >= 1 && s <= 7 && (s % 2) == 1);
    endfunction

    // ---------------- checking ----------------
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk_sys); #1;
            cyc = cyc + 1;
        end while (bus.scan_done_o !== 1'b1 && cyc < 1100);
        if (bus.scan_done_o !== 1'b1) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL scan_done_timeout: got no pulse within %0d cycles, expected one", cyc);
        end
    endtask

    // Called just after a scan_done pulse (step 8): move to mid-step s of the next scan.
    task automatic goto_step(input int s);
        repeat (STEP_DIV * (248 + s) + 2) @(posedge clk_sys);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [11:0] e1,
                                 input logic [11:0] e2, input logic [1:0] e6);
        check({tag, "_joy1"}, {20'd0, bus.joy1_o}, {20'd0, e1});
        check({tag, "_joy2"}, {20'd0, bus.joy2_o}, {20'd0, e2});
        check({tag, "_six"},  {30'd0, bus.six_btn_o}, {30'd0, e6});
    endtask

    typedef struct {
        logic [1:0]  t1;
        logic [11:0] b1;
        logic [1:0]  t2;
        logic [11:0] b2;
        logic [11:0] e1;
        logic [11:0] e2;
        logic [1:0]  e6;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin : main
        int cyc, k, first, second, bad;
        logic [11:0] rb1, rb2;
        logic [12:0] r1, r2;

        vecs[0] = '{PAD_NONE, 12'hFFF, PAD_NONE, 12'hFFF, 12'hFFF, 12'hFFF, 2'b00};
        vecs[1] = '{PAD_MD3,  12'hF3F, PAD_NONE, 12'hFFF, 12'hF3F, 12'hFFF, 2'b00};
        vecs[2] = '{PAD_NONE, 12'hFFF, PAD_MD6,  12'hBFF, 12'hFFF, 12'hBFF, 2'b10};
        vecs[3] = '{PAD_MS,   12'hFEE, PAD_NONE, 12'hFFF, 12'hFEE, 12'hFFF, 2'b00};
        vecs[4] = '{PAD_MD6,  12'h7F6, PAD_MD3,  12'hFD9, 12'h7F6, 12'hFD9, 2'b01};
        vecs[5] = '{PAD_MS,   12'hFD5, PAD_MS,   12'hFFB, 12'hFD5, 12'hFFB, 2'b00};
        vecs[6] = '{PAD_MD6,  12'hFFF, PAD_MD6,  12'hFFF, 12'hFFF, 12'hFFF, 2'b11};

        // Reset state
        #2 reset = 1'b1;
        repeat (20) @(posedge clk_sys);
        #1;
        check("rst_p7", {31'd0, bus.joyX_p7_o}, 32'd1);
        check_outputs("rst", 12'hFFF, 12'hFFF, 2'b00);
        check("rst_done", {31'd0, bus.scan_done_o}, 32'd0);

        // Idle scan: select pattern, first commit time, pulse width and period
        @(negedge clk_sys) reset = 1'b0;
        k = 0; first = -1; second = -1;
        while (k < 1200 && second < 0) begin
            @(posedge clk_sys); #1;
            k = k + 1;
            if (k % 4 == 2 && k < 64)
                check($sformatf("p7_step%0d", k / 4), {31'd0, bus.joyX_p7_o}, {31'd0, exp_p7(k / 4)});
            if (first > 0 && k == first + 1)
                check("done_width", {31'd0, bus.scan_done_o}, 32'd0);
            if (bus.scan_done_o === 1'b1) begin
                if (first < 0) first = k;
                else second = k;
            end
        end
        check("first_done", first, 32'd32);
        check("done_period", second - first, 32'd1024);
        check_outputs("idle", 12'hFFF, 12'hFFF, 2'b00);

        // Vector table; pads change during the idle tail right after a commit
        for (int i = 0; i < 7; i++) begin
            t1 = vecs[i].t1; b1 = vecs[i].b1;
            t2 = vecs[i].t2; b2 = vecs[i].b2;
            wait_done(cyc);
            wait_done(cyc);
            check_outputs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e6);
        end

        // Random pads against the reference model (no opposite directions held)
        for (int i = 0; i < 12; i++) begin
            rb1 = 12'($urandom); rb2 = 12'($urandom);
            if (!rb1[0] && !rb1[1]) rb1[1] = 1'b1;
            if (!rb1[2] && !rb1[3]) rb1[3] = 1'b1;
            if (!rb2[0] && !rb2[1]) rb2[1] = 1'b1;
            if (!rb2[2] && !rb2[3]) rb2[3] = 1'b1;
            t1 = 2'($urandom_range(0, 3)); b1 = rb1;
            t2 = 2'($urandom_range(0, 3)); b2 = rb2;
            r1 = ref_word(t1, b1);
            r2 = ref_word(t2, b2);
            wait_done(cyc);
            wait_done(cyc);
            check_outputs($sformatf("rnd%0d", i), r1[11:0], r2[11:0], {r2[12], r1[12]});
        end

        // Mid-scan change: A released during step 4, after its step-3 sample
        t1 = PAD_MD3; b1 = 12'hFBF;
        t2 = PAD_NONE; b2 = 12'hFFF;
        wait_done(cyc);
        wait_done(cyc);
        check("mid_pre_joy1", {20'd0, bus.joy1_o}, 32'h0000_0FBF);
        goto_step(4);
        b1 = 12'hFFF;
        bad = 0; cyc = 0;
        while (bus.scan_done_o !== 1'b1 && cyc < 100) begin
            @(posedge clk_sys); #1;
            cyc = cyc + 1;
            if (bus.joy1_o !== 12'hFBF) bad = bad + 1;
        end
        check("mid_hold_joy1", {20'd0, bus.joy1_o}, 32'h0000_0FBF);
        check("mid_noglitch", bad, 32'd0);
        wait_done(cyc);
        check("mid_next_joy1", {20'd0, bus.joy1_o}, 32'h0000_0FFF);

        // Reset during step 3 with pads pressed
        t1 = PAD_MD3; b1 = 12'hF3F;
        t2 = PAD_MD6; b2 = 12'hBFF;
        wait_done(cyc);
        wait_done(cyc);
        check_outputs("pre_rst", 12'hF3F, 12'hBFF, 2'b10);
        goto_step(3);
        reset = 1'b1;
        #1;
        check("mid_rst_p7", {31'd0, bus.joyX_p7_o}, 32'd1);
        check_outputs("mid_rst", 12'hFFF, 12'hFFF, 2'b00);
        repeat (300) @(posedge clk_sys);
        @(negedge clk_sys) reset = 1'b0;
        wait_done(cyc);
        check("post_rst_first_done", cyc, 32'd32);
        check_outputs("post_rst", 12'hF3F, 12'hBFF, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sega_joy_scanner.md
# sega_joy_scanner

Free-running poll sequencer for the two DB9 joystick ports. It drives the shared select line (`joyX_p7_o`) through the Sega 3/6-button read protocol and samples both ports' pins at fixed step boundaries. It also detects pad type (Master System, Mega Drive 3-button, Mega Drive 6-button) and publishes debounced, atomically updated 12-bit button words to the core's input mapping. It runs entirely on `clk_sys` and replaces any sequencing derived from video sync.

## Interface
Parameters:
- `STEP_DIV`, default 1536: `clk_sys` cycles per protocol step (64 µs at 24 MHz); legal range ≥ 2.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `joy1_i` in 6: port 1 pins {p9, p6, right, left, down, up}, active-low, asynchronous to `clk_sys`.
- `joy2_i` in 6: port 2 pins, same format.
- `joyX_p7_o` out 1: select line shared by both ports.
- `joy1_o` out 12: port 1 buttons {M,X,Y,Z, S,A,C,B, R,L,D,U}, active-low.
- `joy2_o` out 12: port 2 buttons, same format.
- `six_btn_o` out 2: bit n set means port n+1 reported a 6-button pad in the last scan.
- `scan_done_o` out 1: one-cycle pulse when the outputs commit.

## Operation
- **Input synchronisation:** each input pin passes through a 2-flop synchroniser; all sampling uses the synchronised values.
- **Divider:** the divider counts 0..STEP_DIV-1. A `tick` is issued when the count is STEP_DIV-1. On each tick the current step's action executes and the 8-bit `step` counter increments, wrapping 255→0. A full scan is 256 steps.
- **Step actions** (identical for each port p; "shadow" means per-port shadow registers):
  - step 0: p7←0.
  - step 1: p7←1.
  - step 2: shadow[3:0]←{R,L,D,U}; shadow[5:4]←{p9,p6}; six_pend←0; p7←0.
  - step 3:
    - if R=0 and L=0 (Mega Drive pad): shadow[7:6]←{p9,p6};
    - otherwise: shadow[7:4]←{1,1,p9,p6}.
    - p7←1.
  - step 4: p7←0.
  - step 5: six_pend←1 if R, L, D and U are all 0; p7←1.
  - step 6: shadow[11:8]←{R,L,D,U} if six_pend, else 4'hF; p7←0.
  - step 7: commit both shadows to `joyN_o`, six_pend to `six_btn_o`, and pulse `scan_done_o`; p7←1.
  - steps 8–255: p7 stays 1 (idle; lets 6-button pads time out their internal counter).
- **Atomic commit:** outputs never show partially updated words.

## Timing
- **Reset values:**
  - `joyX_p7_o`=1
  - `joy1_o`=`joy2_o`=12'hFFF
  - `six_btn_o`=0
  - `scan_done_o`=0
  - `step`=0, divider=0, shadows=12'hFFF, synchronisers=all 1.
- `joyX_p7_o` is registered and changes one cycle after the tick.
- Pins are sampled on the tick that ends a step, so each sample sees the select level set at the previous tick, held for STEP_DIV cycles.
- `scan_done_o` is high for exactly one cycle, once per 256·STEP_DIV cycles. The first pulse arrives 8·STEP_DIV cycles after reset release (±1).
- Worst-case pin-to-output latency: 2 (sync) + 256·STEP_DIV + 1 cycles.
- **Reset mid-scan:** outputs return to reset values immediately; the scan restarts at step 0 with no commit of partial shadow data.
- **Pin change during a scan:** a change after its sampling step lands in the next scan; there is no glitch on `joyN_o`.
- Ports are processed in parallel; simultaneous events on both ports have no priority issue.

## Structure
- **Package `joy_pkg`:**
  - step constants `STEP_SEL0`..`STEP_COMMIT` (0–7);
  - bit-index localparams for the 12-bit word (U=0 … M=11);
  - reset constant `JOY_IDLE`=12'hFFF.
- **Sub-module `sega_pad_capture`:** instantiated twice. It holds the synchroniser, shadow, six_pend and output register for one port, and receives `tick` and `step` from the top.
- **Top level:** owns the divider, the step counter and `joyX_p7_o`.

## Test plan
All scenarios use STEP_DIV=4, with a behavioural pad model driving pins from `joyX_p7_o`.
- **Reset/idle:** release reset with no pad (all pins 1).
  - p7 sequence per step is 0,1,0,1,0,1,0 then 1 for 249 steps.
  - `joy1_o`=`joy2_o`=12'hFFF, `six_btn_o`=0.
  - `scan_done_o` pulses every 1024 cycles.
- **3-button MD pad on port 1 with A+Start held:** `joy1_o`=12'hF3F, `six_btn_o`=2'b00, `joy2_o`=12'hFFF.
- **6-button pad on port 2 with X held:** `joy2_o`=12'hBFF, `six_btn_o`=2'b10.
- **Master System pad on port 1 with button 1 (p6) and Up held:** `joy1_o`=12'hFEE, `six_btn_o[0]`=0.
- **Mid-scan pin change:** release a button during step 4.
  - The old value is kept through that scan's commit.
  - The new value appears at the next `scan_done_o`.
- **Reset mid-scan:** assert `reset` during step 3 with a pad pressed.
  - Outputs go to 12'hFFF and p7=1 asynchronously.
  - After release, the first commit reflects the pressed pad correctly.
